bit_serial_add_seq: RTL and testbench



---
 rtl/bit_serial_add_pkg.sv | 18 +
 rtl/bit_serial_add_seq_shift.sv | 33 +++
 rtl/bit_serial_add_seq.sv | 178 +++++++++++++++++
 tb/tb_bit_serial_add_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_add_pkg.sv
// bit_serial_add_pkg
// Shared types and helpers for the bit-serial adder sequencer.
//   state_t   : sequencer FSM states (IDLE, DRIVE, WAIT, DONE)
//   cnt_width : width needed for a counter holding 0..n-1, never below 1
package bit_serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_serial_add_seq_shift.sv
// serial_shift_reg
// Parallel-load shift register that shifts right by one and takes a serial
// bit in at the MSB. Load has priority over shift.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears q)
//   load      : load q with load_val
//   load_val  : parallel load value
//   shift     : shift right one place, sin enters at the MSB
//   sin       : serial input bit
//   q         : register contents
module serial_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             shift,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift) begin
         q <= {sin, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/bit_serial_add_seq.sv
// bit_serial_add_seq
// Sequences an external 1-bit full-adder cell through a WIDTH-bit addition,
// LSB first. The cell's cout is registered as the next step's carry, and each
// step's s is shifted into the result register from the top.
// Optional macro BIT_SERIAL_ADD_OVF_EN adds out_ovf (signed overflow flag).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin   : operands and carry-in
//   fa_a, fa_b, fa_c     : drive to the full-adder cell, held for a whole step
//   fa_s, fa_cout        : cell outputs, valid FA_LAT cycles after driving
//   out_valid / out_ready: result handshake
//   out_sum, out_cout    : WIDTH-bit sum and final carry
//   out_ovf              : (macro only) two's-complement overflow
module bit_serial_add_seq
   import bit_serial_add_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int FA_LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_c,
   input  logic             fa_s,
   input  logic             fa_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef BIT_SERIAL_ADD_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam int WW = cnt_width(FA_LAT);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [WW-1:0] WAIT_INIT = (FA_LAT > 0) ? WW'(FA_LAT - 1) : '0;

   state_t          state_reg;
   logic [CW-1:0]   bit_cnt_reg;
   logic [WW-1:0]   wait_cnt_reg;
   logic            carry_reg;
   logic            busy_reg;
   logic            in_ready_reg;
   logic            out_valid_reg;
`ifdef BIT_SERIAL_ADD_OVF_EN
   logic            c_msb_reg;
`endif

   logic accept;
   logic capture;

   // Index 0 = A, 1 = B, 2 = sum.
   logic [WIDTH-1:0] sh_load [3];
   logic             sh_sin  [3];
   logic [WIDTH-1:0] sh_q    [3];

   always_comb begin
      accept  = (state_reg == IDLE) && in_valid;
      capture = 1'b0;
      // With a combinational cell the result is taken in the DRIVE cycle
      // itself; otherwise only at the end of the WAIT countdown.
      if ((state_reg == DRIVE) && (FA_LAT == 0)) begin
         capture = 1'b1;
      end
      if ((state_reg == WAIT) && (wait_cnt_reg == '0)) begin
         capture = 1'b1;
      end
   end

   assign sh_load[0] = in_a;
   assign sh_load[1] = in_b;
   assign sh_load[2] = '0;
   assign sh_sin[0]  = 1'b0;
   assign sh_sin[1]  = 1'b0;
   assign sh_sin[2]  = fa_s;

   for (genvar gi = 0; gi < 3; gi++) begin : g_sh
      serial_shift_reg #(
         .WIDTH(WIDTH)
      ) u_sh (
         .clk      (clk),
         .rst      (rst),
         .load     (accept),
         .load_val (sh_load[gi]),
         .shift    (capture),
         .sin      (sh_sin[gi]),
         .q        (sh_q[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         wait_cnt_reg  <= '0;
         carry_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
`ifdef BIT_SERIAL_ADD_OVF_EN
         c_msb_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  carry_reg    <= in_cin;
                  bit_cnt_reg  <= '0;
                  busy_reg     <= 1'b1;
                  in_ready_reg <= 1'b0;
                  state_reg    <= DRIVE;
               end
            end
            DRIVE: begin
               if (FA_LAT != 0) begin
                  wait_cnt_reg <= WAIT_INIT;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_reg != '0) begin
                  wait_cnt_reg <= wait_cnt_reg - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // End of a bit step; overrides the next state chosen above.
         if (capture) begin
            carry_reg <= fa_cout;
            if (bit_cnt_reg == LAST_BIT) begin
`ifdef BIT_SERIAL_ADD_OVF_EN
               c_msb_reg     <= carry_reg;
`endif
               bit_cnt_reg   <= '0;
               busy_reg      <= 1'b0;
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end else begin
               bit_cnt_reg   <= bit_cnt_reg + 1'b1;
               state_reg     <= DRIVE;
            end
         end
      end
   end

   // The cell inputs are forced low outside a computation so the cell sees
   // a quiet pattern in IDLE/DONE.
   assign fa_a      = sh_q[0][0] & busy_reg;
   assign fa_b      = sh_q[1][0] & busy_reg;
   assign fa_c      = carry_reg  & busy_reg;
   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_sum   = sh_q[2];
   assign out_cout  = carry_reg;
`ifdef BIT_SERIAL_ADD_OVF_EN
   // Carry into the sign bit differs from carry out of it on signed overflow.
   assign out_ovf   = c_msb_reg ^ carry_reg;
`endif

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// tb_bit_serial_add_seq
// Drives several sequencer instances (different WIDTH / FA_LAT) each wired to
// a behavioural full-adder cell with FA_LAT cycles of output delay, and checks
// results against plain-arithmetic expectations.
// Honours BIT_SERIAL_ADD_OVF_EN for the out_ovf port.
module tb_bit_serial_add_seq;

   localparam int NI   = 7;
   localparam int MAXC = 400;

   function automatic int w_of(input int k);
      return (k < 4) ? 8 : 2;
   endfunction

   function automatic int l_of(input int k);
      case (k)
         0: return 0;
         1: return 5;
         2: return 1;
         3: return 3;
         4: return 0;
         5: return 1;
         default: return 3;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       in_valid_v  [NI];
   logic       in_ready_v  [NI];
   logic [7:0] in_a_v      [NI];
   logic [7:0] in_b_v      [NI];
   logic       in_cin_v    [NI];
   logic       out_ready_v [NI];
   logic       out_valid_v [NI];
   logic [7:0] out_sum_v   [NI];
   logic       out_cout_v  [NI];
   logic       out_ovf_v   [NI];
   logic       fa_a_v      [NI];
   logic       fa_b_v      [NI];
   logic       fa_c_v      [NI];

   int compared   = 0;
   int mismatched = 0;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int W = w_of(gi);
      localparam int L = l_of(gi);
      logic         fa_a, fa_b, fa_c, fa_s, fa_cout, rdy, vld, cout, ovf;
      logic [W-1:0] sum;
      logic         fs0, fc0;

      bit_serial_add_seq #(.WIDTH(W), .FA_LAT(L)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid_v[gi]),
         .in_ready  (rdy),
         .in_a      (in_a_v[gi][W-1:0]),
         .in_b      (in_b_v[gi][W-1:0]),
         .in_cin    (in_cin_v[gi]),
         .fa_a      (fa_a),
         .fa_b      (fa_b),
         .fa_c      (fa_c),
         .fa_s      (fa_s),
         .fa_cout   (fa_cout),
         .out_valid (vld),
         .out_ready (out_ready_v[gi]),
         .out_sum   (sum),
         .out_cout  (cout)
`ifdef BIT_SERIAL_ADD_OVF_EN
         ,
         .out_ovf   (ovf)
`endif
      );
`ifndef BIT_SERIAL_ADD_OVF_EN
      assign ovf = 1'b0;
`endif

      // Full-adder cell with FA_LAT cycles of output delay.
      assign fs0 = fa_a ^ fa_b ^ fa_c;
      assign fc0 = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
      if (L == 0) begin : g_comb
         assign fa_s    = fs0;
         assign fa_cout = fc0;
      end else begin : g_pipe
         logic sp [L];
         logic cp [L];
         always @(posedge clk) begin
            sp[0] <= fs0;
            cp[0] <= fc0;
            for (int i = 1; i < L; i++) begin
               sp[i] <= sp[i-1];
               cp[i] <= cp[i-1];
            end
         end
         assign fa_s    = sp[L-1];
         assign fa_cout = cp[L-1];
      end

      assign in_ready_v[gi]  = rdy;
      assign out_valid_v[gi] = vld;
      assign out_sum_v[gi]   = 8'(sum);
      assign out_cout_v[gi]  = cout;
      assign out_ovf_v[gi]   = ovf;
      assign fa_a_v[gi]      = fa_a;
      assign fa_b_v[gi]      = fa_b;
      assign fa_c_v[gi]      = fa_c;
   end

   // Reference: carry entering bit i is the carry out of the low i bits.
   function automatic logic carry_into(input int a, input int b, input int cin, input int i);
      int m;
      m = (1 << i) - 1;
      return 1'(((a & m) + (b & m) + cin) >> i);
   endfunction

   function automatic logic ref_ovf(input int w, input int a, input int b, input int cin);
      int sa, sb, t;
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      t  = sa + sb + cin;
      return (t > (1 << (w - 1)) - 1) || (t < -(1 << (w - 1)));
   endfunction

   // Runs one transaction on instance k and reports what was observed.
   // hold > 0 keeps out_ready low that many cycles in DONE while junk
   // operands are offered with in_valid high.
   task automatic do_txn(input int k, input int a, input int b, input int cin, input int hold,
                         output logic [7:0] s, output logic c, output logic o, output int lat,
                         output bit fa_ok, output bit hold_ok, output bit post_ok, output bit tmo);
      int w, l, n, i;
      w = w_of(k); l = l_of(k);
      s = '0; c = 1'b0; o = 1'b0; lat = 0;
      fa_ok = 1'b1; hold_ok = 1'b1; post_ok = 1'b1; tmo = 1'b0;
      @(negedge clk);
      n = 0;
      while (in_ready_v[k] !== 1'b1 && n < MAXC) begin
         @(negedge clk);
         n++;
      end
      if (n >= MAXC) begin
         tmo = 1'b1;
         return;
      end
      in_a_v[k] = 8'(a); in_b_v[k] = 8'(b); in_cin_v[k] = 1'(cin);
      in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b0;
      @(posedge clk);
      n = 0;
      @(negedge clk);
      in_valid_v[k] = (hold > 0);
      in_a_v[k] = 8'($urandom); in_b_v[k] = 8'($urandom);
      while (out_valid_v[k] !== 1'b1 && n < MAXC) begin
         if (n < w * (l + 1)) begin
            i = n / (l + 1);
            if (fa_a_v[k] !== 1'((a >> i) & 1) || fa_b_v[k] !== 1'((b >> i) & 1) ||
                fa_c_v[k] !== carry_into(a, b, cin, i))
               fa_ok = 1'b0;
         end
         @(negedge clk);
         n++;
         in_a_v[k] = 8'($urandom); in_b_v[k] = 8'($urandom);
      end
      if (n >= MAXC) begin
         in_valid_v[k] = 1'b0;
         tmo = 1'b1;
         return;
      end
      lat = n;
      s = out_sum_v[k]; c = out_cout_v[k]; o = out_ovf_v[k];
      for (int h = 0; h < hold; h++) begin
         if (in_ready_v[k] !== 1'b0 || out_valid_v[k] !== 1'b1 ||
             out_sum_v[k] !== s || out_cout_v[k] !== c)
            hold_ok = 1'b0;
         @(negedge clk);
         in_a_v[k] = 8'($urandom); in_b_v[k] = 8'($urandom);
      end
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b1;
      @(negedge clk);
      post_ok = (in_ready_v[k] === 1'b1) && (out_valid_v[k] === 1'b0);
      out_ready_v[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (8) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (in_ready_v[k] !== 1'b1 || out_valid_v[k] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hs[%0d]: in_ready=%b out_valid=%b, required 1/0", k, in_ready_v[k], out_valid_v[k]);
         end
         compared++;
         if (out_sum_v[k] !== 8'h00 || out_cout_v[k] !== 1'b0 || out_ovf_v[k] !== 1'b0 ||
             {fa_a_v[k], fa_b_v[k], fa_c_v[k]} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_data[%0d]: sum=%h cout=%b ovf=%b fa=%b%b%b, required all zero", k,
                     out_sum_v[k], out_cout_v[k], out_ovf_v[k], fa_a_v[k], fa_b_v[k], fa_c_v[k]);
         end
      end
      rst = 1'b0;
      $display("txn reset: all %0d instances checked", NI);
   endtask

   task automatic test_basic();
      int tv [3][3] = '{'{'h0F, 'h01, 0}, '{'hFF, 'h01, 0}, '{'h7F, 'h01, 0}};
      logic [7:0] s; logic c, o; int lat; bit fa_ok, hold_ok, post_ok, tmo;
      int exp;
      for (int t = 0; t < 3; t++) begin
         do_txn(0, tv[t][0], tv[t][1], tv[t][2], 0, s, c, o, lat, fa_ok, hold_ok, post_ok, tmo);
         exp = tv[t][0] + tv[t][1] + tv[t][2];
         $display("txn basic: a=%h b=%h cin=%0d -> sum=%h cout=%b ovf=%b lat=%0d", tv[t][0], tv[t][1], tv[t][2], s, c, o, lat);
         compared++;
         if (tmo || {c, s} !== 9'(exp)) begin
            mismatched++;
            $display("FAIL basic_sum[%0d]: got {cout,sum}=%h, required %h (timeout=%b)", t, {c, s}, 9'(exp), tmo);
         end
         compared++;
         if (lat != 8 || !fa_ok || !post_ok) begin
            mismatched++;
            $display("FAIL basic_seq[%0d]: lat=%0d fa_ok=%b post_ok=%b, required 8/1/1", t, lat, fa_ok, post_ok);
         end
`ifdef BIT_SERIAL_ADD_OVF_EN
         compared++;
         if (o !== ref_ovf(8, tv[t][0], tv[t][1], tv[t][2])) begin
            mismatched++;
            $display("FAIL basic_ovf[%0d]: got %b, required %b", t, o, ref_ovf(8, tv[t][0], tv[t][1], tv[t][2]));
         end
`endif
      end
   endtask

   task automatic test_fa_lat();
      logic [7:0] s; logic c, o; int lat; bit fa_ok, hold_ok, post_ok, tmo;
      do_txn(1, 'hA5, 'h5A, 1, 0, s, c, o, lat, fa_ok, hold_ok, post_ok, tmo);
      $display("txn fa_lat5: a=a5 b=5a cin=1 -> sum=%h cout=%b lat=%0d fa_ok=%b", s, c, lat, fa_ok);
      compared++;
      if (tmo || s !== 8'h00 || c !== 1'b1) begin
         mismatched++;
         $display("FAIL fa_lat_sum: got sum=%h cout=%b, required 00/1 (timeout=%b)", s, c, tmo);
      end
      compared++;
      if (lat != 48) begin
         mismatched++;
         $display("FAIL fa_lat_latency: got %0d cycles, required 48", lat);
      end
      compared++;
      if (!fa_ok) begin
         mismatched++;
         $display("FAIL fa_lat_hold: fa_* not held at the expected bit values, got fa_ok=0 required 1");
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] s; logic c, o; int lat; bit fa_ok, hold_ok, post_ok, tmo;
      do_txn(0, 'h12, 'h34, 1, 10, s, c, o, lat, fa_ok, hold_ok, post_ok, tmo);
      $display("txn backpressure: a=12 b=34 cin=1 -> sum=%h cout=%b hold_ok=%b post_ok=%b", s, c, hold_ok, post_ok);
      compared++;
      if (tmo || {c, s} !== 9'h047) begin
         mismatched++;
         $display("FAIL bp_sum: got {cout,sum}=%h, required 047", {c, s});
      end
      compared++;
      if (!hold_ok) begin
         mismatched++;
         $display("FAIL bp_hold: result/handshake moved while out_ready low, got hold_ok=0 required 1");
      end
      compared++;
      if (!post_ok) begin
         mismatched++;
         $display("FAIL bp_release: after accept in_ready/out_valid wrong, got post_ok=0 required 1");
      end
      do_txn(0, 'h20, 'h22, 0, 0, s, c, o, lat, fa_ok, hold_ok, post_ok, tmo);
      $display("txn after_bp: a=20 b=22 cin=0 -> sum=%h cout=%b", s, c);
      compared++;
      if (tmo || {c, s} !== 9'h042) begin
         mismatched++;
         $display("FAIL bp_next: got {cout,sum}=%h, required 042", {c, s});
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] s; logic c, o; int lat; bit fa_ok, hold_ok, post_ok, tmo;
      bit pulse;
      @(negedge clk);
      in_a_v[0] = 8'h55; in_b_v[0] = 8'h33; in_cin_v[0] = 1'b0; in_valid_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      compared++;
      if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || out_sum_v[0] !== 8'h00 ||
          out_cout_v[0] !== 1'b0 || {fa_a_v[0], fa_b_v[0], fa_c_v[0]} !== 3'b000) begin
         mismatched++;
         $display("FAIL mid_reset: rdy=%b vld=%b sum=%h cout=%b fa=%b%b%b, required 1/0/00/0/000",
                  in_ready_v[0], out_valid_v[0], out_sum_v[0], out_cout_v[0], fa_a_v[0], fa_b_v[0], fa_c_v[0]);
      end
      rst = 1'b0;
      pulse = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid_v[0] !== 1'b0) pulse = 1'b1;
      end
      compared++;
      if (pulse) begin
         mismatched++;
         $display("FAIL mid_no_pulse: out_valid rose after abort, got 1 required 0");
      end
      do_txn(0, 'h03, 'h03, 0, 0, s, c, o, lat, fa_ok, hold_ok, post_ok, tmo);
      $display("txn after_reset: a=03 b=03 cin=0 -> sum=%h cout=%b", s, c);
      compared++;
      if (tmo || {c, s} !== 9'h006) begin
         mismatched++;
         $display("FAIL mid_fresh: got {cout,sum}=%h, required 006", {c, s});
      end
   endtask

   task automatic test_random();
      logic [7:0] s; logic c, o; int lat; bit fa_ok, hold_ok, post_ok, tmo;
      int k, w, l, a, b, cin, hold, exp, got;
      for (int r = 0; r < 1000; r++) begin
         k = r % NI; w = w_of(k); l = l_of(k);
         a = int'($urandom_range(0, (1 << w) - 1));
         b = int'($urandom_range(0, (1 << w) - 1));
         cin = int'($urandom_range(0, 1));
         hold = int'($urandom_range(0, 2));
         do_txn(k, a, b, cin, hold, s, c, o, lat, fa_ok, hold_ok, post_ok, tmo);
         exp = a + b + cin;
         got = (int'(c) << w) | int'(s);
         $display("txn rand %0d: inst=%0d W=%0d L=%0d a=%h b=%h cin=%0d -> %h (exp %h) lat=%0d",
                  r, k, w, l, a, b, cin, got, exp, lat);
         compared++;
         if (tmo || $isunknown({c, s}) || got != exp) begin
            mismatched++;
            $display("FAIL rand_sum[%0d]: got %h, required %h (timeout=%b)", r, got, exp, tmo);
         end
         compared++;
         if (lat != w * (l + 1) || !fa_ok || !hold_ok || !post_ok) begin
            mismatched++;
            $display("FAIL rand_seq[%0d]: lat=%0d fa=%b hold=%b post=%b, required %0d/1/1/1",
                     r, lat, fa_ok, hold_ok, post_ok, w * (l + 1));
         end
`ifdef BIT_SERIAL_ADD_OVF_EN
         compared++;
         if (o !== ref_ovf(w, a, b, cin)) begin
            mismatched++;
            $display("FAIL rand_ovf[%0d]: got %b, required %b", r, o, ref_ovf(w, a, b, cin));
         end
`endif
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         in_valid_v[k] = 1'b0; in_a_v[k] = '0; in_b_v[k] = '0;
         in_cin_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      end
      test_reset();
      test_basic();
      test_fa_lat();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
      $fatal(1, "watchdog");
   end

endmodule
